i2s_tx_serializer: RTL
======================

# i2s_tx_serializer

I2S transmit serializer in the codec bit-clock (SCLK) domain, directly downstream of the fast-to-slow strobe synchronizer. It detects each new-sample strobe, captures a stereo sample pair into a pending buffer, and shifts it out MSB-first in standard I2S format (one-bit delay after the LRCK edge). It generates LRCK and a frame marker, and reports underrun and overrun.

## Interface
- DATA_WIDTH, 16: bits per channel sample; legal range 8..SLOT_WIDTH-1.
- SLOT_WIDTH, 32: SCLK cycles per channel slot. A frame is 2*SLOT_WIDTH cycles.
- Clk  in  1  SCLK-rate clock. Single clock domain; all logic on posedge.
- Rst_N  in  1  Reset: synchronous, active-low.
- Sample_Strobe  in  1  Synchronized new-sample level from the CDC stage; each rising edge marks one new sample.
- Sample_Left  in  DATA_WIDTH  Left sample, two's complement. Stable while Sample_Strobe is high.
- Sample_Right  in  DATA_WIDTH  Right sample. Same stability rule as Sample_Left.
- Lrclk  out  1  Word select: 0 = left slot, 1 = right slot.
- Sdata  out  1  Serial data.
- Frame_Start  out  1  One-cycle pulse at frame position 0.
- Underrun  out  1  One-cycle pulse: a frame started with no new sample.
- Overrun  out  1  One-cycle pulse: a pending sample was overwritten before use.

## Operation
- Position counter pos runs 0..2*SLOT_WIDTH-1 and wraps to 0. Slot position p = pos mod SLOT_WIDTH.
- Strobe edge detect: register strobe_prev. A rising edge occurs when Sample_Strobe=1 and strobe_prev=0.
  - On a rising edge: capture Sample_Left and Sample_Right into pend_l/pend_r and set pend_v.
  - If pend_v is already 1: overwrite the pending pair and pulse Overrun.
- Load cycle (pos = 2*SLOT_WIDTH-1): frame registers tx_l/tx_r are set for the next frame.
  - If pend_v=1: tx_l/tx_r take pend_l/pend_r; pend_v clears.
  - If pend_v=0: Underrun is asserted together with the next Frame_Start. tx_l/tx_r behave per Configuration.
- Simultaneous strobe edge and load cycle: the load sees pend_v as it was before the edge. The new pair becomes pending, and pend_v=1 after the cycle.
- Output mapping:
  - Lrclk = (pos >= SLOT_WIDTH).
  - Sdata = bit (DATA_WIDTH-p) of the current channel's tx word for p in 1..DATA_WIDTH; otherwise 0. This includes p=0, which is the I2S delay bit.
- Implementation: a shift register loaded at each slot boundary is acceptable if the output matches this mapping bit-for-bit.

## Timing
- All outputs are registered. Reset values while Rst_N=0: Lrclk=0, Sdata=0, Frame_Start=0, Underrun=0, Overrun=0. Internal reset values: pos=0, pend_v=0, tx_l=tx_r=0, strobe_prev=0.
- Mid-operation reset: at the first edge with Rst_N=0, all outputs and internal state return to reset values. Any pending sample is discarded.
- First rising edge with Rst_N=1 is cycle 0, and outputs show position 0: Frame_Start=1, Lrclk=0.
- In cycle k, outputs correspond to pos = k mod 2*SLOT_WIDTH.
- Frame 0 after reset transmits zeros and never asserts Underrun.
- Latency: a strobe edge in frame n (at any pos except the load cycle) sends the left MSB at position 1 of frame n+1. An edge at the load cycle sends it at position 1 of frame n+2.
- Overrun asserts in the cycle after the offending edge. Underrun asserts in the same cycle as Frame_Start.
- Board level: the codec receives SCLK as inverted Clk, so Sdata and Lrclk are stable at the codec's sampling edge.

## Configuration
- I2S_TX_UNDERRUN_MUTE_EN
  - Defined: on underrun, tx_l and tx_r load 0, so the frame is silent.
  - Undefined: on underrun, tx_l and tx_r keep their previous values, so the last sample repeats.
  - Underrun is pulsed in both cases.

## Test plan
All scenarios use DATA_WIDTH=16, SLOT_WIDTH=32.
- Reset: Rst_N low for 5 cycles with Sample_Strobe toggling -> all outputs 0. After release: Frame_Start at cycle 0 and 64; Lrclk 0 for 32 cycles, then 1 for 32.
- Strobe at pos 10 of frame 0 with L=16'hA5C3, R=16'h0F0F -> frame 1: Sdata at p1..16 = 1010010111000011 (left) and 0000111100001111 (right); p0 and p17..31 = 0; no Underrun.
- No strobe during frame 1 -> Underrun pulse at start of frame 2. Frame 2 repeats A5C3/0F0F with the macro undefined, and is all zero with I2S_TX_UNDERRUN_MUTE_EN defined.
- Two strobe edges in one frame (L=16'h1111, then L=16'h2222) -> one Overrun pulse; next frame carries 16'h2222.
- Strobe edge exactly at pos 63 -> Underrun on the immediately following frame; the sample appears in the frame after that.
- Rst_N low for one cycle at pos 20 with pend_v=1 -> next edge: all outputs 0. Restart at pos 0; the discarded sample never appears.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer, SCLK domain.
// Detects each rising edge of the synchronized new-sample strobe, holds the
// stereo pair in a pending buffer, and shifts it out MSB-first in standard
// I2S framing (data starts one bit after the LRCK edge). LRCK, a frame-start
// pulse, and underrun/overrun pulses are generated alongside.
//
// Optional feature macro: I2S_TX_UNDERRUN_MUTE_EN
//   defined   - a frame with no new sample is transmitted as silence
//   undefined - a frame with no new sample repeats the previous pair
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_N,
    input  logic                  Sample_Strobe,
    input  logic [DATA_WIDTH-1:0] Sample_Left,
    input  logic [DATA_WIDTH-1:0] Sample_Right,
    output logic                  Lrclk,
    output logic                  Sdata,
    output logic                  Frame_Start,
    output logic                  Underrun,
    output logic                  Overrun
);

    localparam int FRAME_LEN = 2 * SLOT_WIDTH;
    localparam int POS_W     = $clog2(FRAME_LEN);
    localparam int IDX_W     = $clog2(DATA_WIDTH);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] SLOT_POS = POS_W'(SLOT_WIDTH);
    localparam logic [POS_W-1:0] DATA_POS = POS_W'(DATA_WIDTH);

    // pos_q is the frame position the outputs will show after the next edge.
    // The cycle that just ended therefore sat at pos_q-1, so pos_q == 0 marks
    // the end of the last cycle of a frame (the load cycle).
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  run_q;
    logic                  strobe_prev_q;
    logic                  pend_v_q, pend_v_d;
    logic [DATA_WIDTH-1:0] pend_l_q, pend_l_d;
    logic [DATA_WIDTH-1:0] pend_r_q, pend_r_d;
    logic [DATA_WIDTH-1:0] tx_l_q, tx_l_d;
    logic [DATA_WIDTH-1:0] tx_r_q, tx_r_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;

    logic                  load;
    logic                  strobe_rise;
    logic [POS_W-1:0]      slot_pos;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [IDX_W-1:0]      bit_idx;

    // The very first edge after reset starts frame 0; no frame ended there,
    // so no load (and no underrun) happens on it.
    assign load        = run_q && (pos_q == '0);
    assign strobe_rise = Sample_Strobe && !strobe_prev_q;

    // Position counter, pending buffer and frame-register next state.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        pos_d      = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
        pend_v_d   = pend_v_q;
        pend_l_d   = pend_l_q;
        pend_r_d   = pend_r_q;
        tx_l_d     = tx_l_q;
        tx_r_d     = tx_r_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;

        if (load) begin
            if (pend_v_q) begin
                tx_l_d   = pend_l_q;
                tx_r_d   = pend_r_q;
                pend_v_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                tx_l_d = '0;
                tx_r_d = '0;
`else
                tx_l_d = tx_l_q;
                tx_r_d = tx_r_q;
`endif
            end
        end

        // Evaluated after the load so a simultaneous load consumes the old
        // pair first; overrun only flags a pair that is really lost.
        if (strobe_rise) begin
            overrun_d = pend_v_d;
            pend_l_d  = Sample_Left;
            pend_r_d  = Sample_Right;
            pend_v_d  = 1'b1;
        end
    end

    // Output mapping for the position about to be shown.
    always_comb begin
        lrclk_d       = (pos_q >= SLOT_POS);
        slot_pos      = lrclk_d ? (pos_q - SLOT_POS) : pos_q;
        cur_word      = lrclk_d ? tx_r_q : tx_l_q;
        bit_idx       = IDX_W'(DATA_POS - slot_pos);
        sdata_d       = ((slot_pos != '0) && (slot_pos <= DATA_POS)) ? cur_word[bit_idx] : 1'b0;
        frame_start_d = (pos_q == '0);
    end

    // Control state, frame registers and registered outputs, synchronously reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!Rst_N) begin
            pos_q         <= '0;
            run_q         <= 1'b0;
            strobe_prev_q <= 1'b0;
            pend_v_q      <= 1'b0;
            tx_l_q        <= '0;
            tx_r_q        <= '0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            run_q         <= 1'b1;
            strobe_prev_q <= Sample_Strobe;
            pend_v_q      <= pend_v_d;
            tx_l_q        <= tx_l_d;
            tx_r_q        <= tx_r_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    // Pending sample data, qualified by pend_v_q.
    always_ff @(posedge Clk) begin
        // NOTE: pure data registers with a separate valid flag are left
        // unreset; the cleared valid bit already discards their contents.
        pend_l_q <= pend_l_d;
        pend_r_q <= pend_r_d;
    end

    assign Lrclk       = lrclk_q;
    assign Sdata       = sdata_q;
    assign Frame_Start = frame_start_q;
    assign Underrun    = underrun_q;
    assign Overrun     = overrun_q;

endmodule
